// File: rtl/mat_key_debounce.sv
// 4x4 matrix keypad scanner: drives one row low at a time, assembles a 16-key
// frame per scan and debounces it into a stable level vector plus press pulses.
module mat_key_debounce #(
  parameter int SCAN_DIV     = 2500,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  output logic [15:0] btn_level,
  output logic [15:0] btn_pulse,
  output logic        key_valid,
  output logic [3:0]  key_code
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_CNT);

  logic [3:0]    col_meta_q, col_meta_d;
  logic [3:0]    col_sync_q, col_sync_d;
  logic [CW-1:0] slot_cnt_q, slot_cnt_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [15:0]   frame_q, frame_d;
  logic          frame_done_q, frame_done_d;
  logic [15:0]   prev_frame_q, prev_frame_d;
  logic [SW-1:0] stable_cnt_q, stable_cnt_d;
  logic [15:0]   btn_level_q, btn_level_d;
  logic [15:0]   btn_pulse_q, btn_pulse_d;
  logic          key_valid_q, key_valid_d;
  logic [3:0]    key_code_q, key_code_d;

  always_comb begin
    col_meta_d   = col;
    col_sync_d   = col_meta_q;
    slot_cnt_d   = slot_cnt_q + CW'(1);
    row_idx_d    = row_idx_q;
    frame_d      = frame_q;
    frame_done_d = 1'b0;
    prev_frame_d = prev_frame_q;
    stable_cnt_d = stable_cnt_q;
    btn_level_d  = btn_level_q;
    btn_pulse_d  = '0;
    key_valid_d  = 1'b0;
    key_code_d   = key_code_q;

    // Sample at the end of the slot so the synchroniser has settled on this row.
    if (slot_cnt_q == SLOT_LAST) begin
      slot_cnt_d = '0;
      row_idx_d  = row_idx_q + 2'd1;
      frame_d[{row_idx_q, 2'b00} +: 4] = ~col_sync_q;
      frame_done_d = (row_idx_q == 2'd3);
    end

    if (frame_done_q) begin
      if (frame_q != prev_frame_q) begin
        prev_frame_d = frame_q;
        stable_cnt_d = SW'(1);
      end else if (stable_cnt_q < STABLE_MAX) begin
        stable_cnt_d = stable_cnt_q + SW'(1);
        if (stable_cnt_d == STABLE_MAX) begin
          btn_level_d = prev_frame_q;
          btn_pulse_d = prev_frame_q & ~btn_level_q;
          key_valid_d = |btn_pulse_d;
          // Walk downwards so the lowest pressed index wins.
          for (int i = 15; i >= 0; i--) begin
            if (btn_pulse_d[i]) key_code_d = 4'(i);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_meta_q   <= 4'hF;
      col_sync_q   <= 4'hF;
      slot_cnt_q   <= '0;
      row_idx_q    <= '0;
      frame_q      <= '0;
      frame_done_q <= 1'b0;
      prev_frame_q <= '0;
      stable_cnt_q <= '0;
      btn_level_q  <= '0;
      btn_pulse_q  <= '0;
      key_valid_q  <= 1'b0;
      key_code_q   <= '0;
    end else begin
      col_meta_q   <= col_meta_d;
      col_sync_q   <= col_sync_d;
      slot_cnt_q   <= slot_cnt_d;
      row_idx_q    <= row_idx_d;
      frame_q      <= frame_d;
      frame_done_q <= frame_done_d;
      prev_frame_q <= prev_frame_d;
      stable_cnt_q <= stable_cnt_d;
      btn_level_q  <= btn_level_d;
      btn_pulse_q  <= btn_pulse_d;
      key_valid_q  <= key_valid_d;
      key_code_q   <= key_code_d;
    end
  end

  assign row       = ~(4'b0001 << row_idx_q);
  assign btn_level = btn_level_q;
  assign btn_pulse = btn_pulse_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;

endmodule
